mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RISC-V pipeline, between the ex_mem pipeline register and the mem_wb register. Non-memory instructions pass straight through to writeback combinationally. Loads and stores run as multi-cycle byte-serial transfers on the 8-bit memory-controller port. While a transfer is in flight the stage raises a stall request to ctrl, which freezes everything upstream.

## Interface
- No parameters; data 32 bits, register address 5 bits.
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ex_wd  in  5  destination register
- ex_wreg  in  1  register write enable
- ex_wdata  in  32  ALU result (pass-through data)
- ex_mem_rd  in  1  instruction is a load
- ex_mem_we  in  1  instruction is a store
- ex_funct3  in  3  RV32I load/store funct3
- ex_mem_addr  in  32  effective byte address
- ex_store_data  in  32  store data (rs2)
- mem_wd  out  5  to mem_wb: destination register
- mem_wreg  out  1  to mem_wb: write enable
- mem_wdata  out  32  to mem_wb: write data
- mc_req  out  1  byte request to memory controller (registered)
- mc_we  out  1  1 = write byte (registered)
- mc_addr  out  32  byte address (registered)
- mc_wdata  out  8  write byte (registered)
- mc_rdata  in  8  read byte, valid when mc_ack = 1
- mc_ack  in  1  current byte complete
- stall_req  out  1  to ctrl: hold ex_mem and all earlier stages

## Operation
- **Access type**
  - A memory op is ex_mem_rd | ex_mem_we; if both are set, the op is a load.
- **Byte count N from funct3[1:0]**
  - 00 gives 1 byte, 01 gives 2 bytes; 10 and 11 give 4 bytes.
- **Load extension**
  - funct3[2] = 0 sign-extends the loaded value; funct3[2] = 1 zero-extends it.
- **Addressing**
  - Little-endian; byte k goes to ex_mem_addr + k.
  - No alignment check; the 32-bit address wraps modulo 2^32.
- **FSM states: IDLE, XFER, DONE.**
  - **IDLE**
    - Non-memory op: mem_* = ex_* combinationally, stall_req = 0.
    - Memory op: stall_req = 1 and mem_wreg = 0 (bubble).
    - At the clock edge: load mc_addr = ex_mem_addr, mc_we = ex_mem_we, mc_wdata = ex_store_data[7:0], mc_req = 1, cnt = 0, clear the read buffer, go to XFER.
  - **XFER**
    - stall_req = 1, mem_wreg = 0.
    - On mc_ack: if the op is a load, latch mc_rdata into buffer byte cnt.
    - On mc_ack with cnt < N−1: cnt++, mc_addr++, mc_wdata = next store byte, mc_req stays 1.
    - On mc_ack with cnt = N−1: mc_req = 0, go to DONE.
    - Without mc_ack, all mc_* outputs hold.
  - **DONE** (exactly one cycle)
    - stall_req = 0 and mem_wd = ex_wd.
    - Load: mem_wreg = ex_wreg and mem_wdata = the extended buffer.
    - Store: mem_wreg = 0 and mem_wdata = 0.
    - ex_mem advances at this edge; go to IDLE.
- **Input stability**
  - ex_* inputs are required stable while stall_req = 1; ctrl guarantees this.
- **Reset**
  - Reset at any time, including mid-transfer, forces IDLE, cnt = 0, buffer = 0 and mc_req / mc_we / mc_addr / mc_wdata = 0.
  - During rst: stall_req = 0, mem_wreg = 0, mem_wd = 0, mem_wdata = 0.
  - An interrupted transfer is abandoned; the controller drops it when it sees mc_req = 0.

## Timing
- **Non-memory ops:** 0 cycles of added latency, never stall.
- **Memory ops, mc_ack back-to-back:** 1 (IDLE) + N (XFER) + 1 (DONE) cycles.
  - Word access: 6 cycles. Byte access: 3 cycles.
- **Wait states:** each cycle with mc_ack = 0 adds one cycle.
- **Request/ack handshake**
  - mc_req rises the cycle after the memory op appears in IDLE.
  - mc_ack is only meaningful while mc_req = 1 and is ignored otherwise.
- **Back-to-back memory ops**
  - The next op is sampled in the cycle after DONE, so there is no gap beyond the DONE cycle.

## Test plan
- **ALU pass-through:** ex_wd = 5, ex_wreg = 1, ex_wdata = 0x1234, no memory op → same cycle mem_wd = 5, mem_wreg = 1, mem_wdata = 0x1234, stall_req = 0, mc_req never asserts.
- **LW, ack every cycle:** address 0x100, memory bytes 0x78, 0x56, 0x34, 0x12 → addresses 0x100–0x103 requested in order, stall_req high for 5 cycles, DONE shows mem_wdata = 0x12345678.
- **LB / LBU:** byte 0x80 → LB gives 0xFFFFFF80, LBU gives 0x00000080. **LH** on bytes 0xFE, 0xFF → 0xFFFFFFFE.
- **SH:** address 0x2000, data 0xAABBCCDD → writes 0xDD to 0x2000 and 0xCC to 0x2001, mc_we = 1, DONE shows mem_wreg = 0.
- **Wait states:** SW with mc_ack low for 3 cycles before every byte → mc_addr / mc_wdata held during waits, total latency 18 cycles.
- **Reset mid-LW:** assert rst after byte 1 is acked → next cycle IDLE, mc_req = 0, stall_req = 0. A following LW completes correctly with no stale buffer bytes.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: ALU results pass straight through, loads/stores run
// as byte-serial transfers on the 8-bit memory-controller port while stalling upstream.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_we,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mc_req,
  output logic        mc_we,
  output logic [31:0] mc_addr,
  output logic [7:0]  mc_wdata,
  input  logic [7:0]  mc_rdata,
  input  logic        mc_ack,
  output logic        stall_req
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  next_cnt;
  logic [1:0]  last;
  logic [31:0] rbuf;
  logic [31:0] load_val;
  logic [31:0] store_shift;
  logic        mem_op;
  logic        is_load;
  logic        is_store;

  // A load wins when both request bits are set, so writes only happen for pure stores.
  assign mem_op   = ex_mem_rd | ex_mem_we;
  assign is_load  = ex_mem_rd;
  assign is_store = ex_mem_we & ~ex_mem_rd;

  assign next_cnt    = cnt + 2'd1;
  assign store_shift = ex_store_data >> {next_cnt, 3'b000};

  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   last = 2'd0;
      2'b01:   last = 2'd1;
      default: last = 2'd3;
    endcase
  end

  // funct3[2] selects zero-extension; otherwise the top loaded bit is replicated.
  always_comb begin
    case (last)
      2'd0:    load_val = ex_funct3[2] ? {24'b0, rbuf[7:0]}  : {{24{rbuf[7]}},  rbuf[7:0]};
      2'd1:    load_val = ex_funct3[2] ? {16'b0, rbuf[15:0]} : {{16{rbuf[15]}}, rbuf[15:0]};
      default: load_val = rbuf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      rbuf     <= 32'd0;
      mc_req   <= 1'b0;
      mc_we    <= 1'b0;
      mc_addr  <= 32'd0;
      mc_wdata <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            mc_req   <= 1'b1;
            mc_we    <= is_store;
            mc_addr  <= ex_mem_addr;
            mc_wdata <= ex_store_data[7:0];
            cnt      <= 2'd0;
            rbuf     <= 32'd0;
            state    <= XFER;
          end
        end
        XFER: begin
          if (mc_ack) begin
            if (is_load)
              rbuf[{cnt, 3'b000} +: 8] <= mc_rdata;
            if (cnt == last) begin
              mc_req <= 1'b0;
              state  <= DONE;
            end else begin
              cnt      <= next_cnt;
              mc_addr  <= mc_addr + 32'd1;
              mc_wdata <= store_shift[7:0];
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback/stall outputs stay combinational so ALU ops see no added latency.
  always_comb begin
    stall_req = 1'b0;
    mem_wd    = ex_wd;
    mem_wreg  = ex_wreg;
    mem_wdata = ex_wdata;
    if (rst) begin
      mem_wd    = 5'd0;
      mem_wreg  = 1'b0;
      mem_wdata = 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            stall_req = 1'b1;
            mem_wreg  = 1'b0;
          end
        end
        XFER: begin
          stall_req = 1'b1;
          mem_wreg  = 1'b0;
        end
        DONE: begin
          if (is_load) begin
            mem_wdata = load_val;
          end else begin
            mem_wreg  = 1'b0;
            mem_wdata = 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: the bench plays the memory controller and
// predicts every transfer from a byte-addressed memory model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_mem_rd;
  logic        ex_mem_we;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mc_req;
  logic        mc_we;
  logic [31:0] mc_addr;
  logic [7:0]  mc_wdata;
  logic [7:0]  mc_rdata;
  logic        mc_ack;
  logic        stall_req;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [logic [31:0]];

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_mem_rd(ex_mem_rd), .ex_mem_we(ex_mem_we), .ex_funct3(ex_funct3),
    .ex_mem_addr(ex_mem_addr), .ex_store_data(ex_store_data),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_rdata(mc_rdata), .mc_ack(mc_ack), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] fetchByte(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  // wait_per_byte < 0 picks a random 0..2 wait states before each byte.
  task automatic applyStimulus(input logic rd, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] sdata,
                               input logic [31:0] alu, input logic [4:0] wd,
                               input logic wreg, input int wait_per_byte);
    int n, k, guard, waits_left;
    logic store, memop;
    logic [31:0] a;
    longint unsigned loaded;
    longint expect_val;
    ex_mem_rd = rd; ex_mem_we = we; ex_funct3 = f3; ex_mem_addr = addr;
    ex_store_data = sdata; ex_wdata = alu; ex_wd = wd; ex_wreg = wreg;
    mc_ack = 1'b0;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    store = we & ~rd;
    memop = rd | we;
    #1;
    if (!memop) begin
      checkOutput("pass_wd", 32'(mem_wd), 32'(wd));
      checkOutput("pass_wreg", 32'(mem_wreg), 32'(wreg));
      checkOutput("pass_wdata", mem_wdata, alu);
      checkOutput("pass_stall", 32'(stall_req), 0);
      tick();
      checkOutput("pass_no_req", 32'(mc_req), 0);
      return;
    end
    checkOutput("idle_stall", 32'(stall_req), 1);
    checkOutput("idle_wreg", 32'(mem_wreg), 0);
    checkOutput("idle_req", 32'(mc_req), 0);
    tick();
    k = 0;
    guard = 0;
    loaded = 0;
    waits_left = (wait_per_byte < 0) ? $urandom_range(0, 2) : wait_per_byte;
    while (k < n && guard < 100) begin
      a = addr + 32'(k);
      checkOutput("xfer_stall", 32'(stall_req), 1);
      checkOutput("xfer_wreg", 32'(mem_wreg), 0);
      checkOutput("xfer_req", 32'(mc_req), 1);
      checkOutput("xfer_addr", mc_addr, a);
      checkOutput("xfer_we", 32'(mc_we), 32'(store));
      if (store) checkOutput("xfer_wdata", 32'(mc_wdata), (sdata >> (8 * k)) & 32'hFF);
      if (waits_left > 0) begin
        waits_left--;
        mc_ack = 1'b0;
        mc_rdata = 8'($urandom);
        tick();
      end else begin
        mc_ack = 1'b1;
        if (store) begin
          mem[a] = 8'((sdata >> (8 * k)) & 32'hFF);
          mc_rdata = 8'($urandom);
        end else begin
          mc_rdata = fetchByte(a);
          loaded = loaded + (longint'(mc_rdata) << (8 * k));
        end
        tick();
        k++;
        waits_left = (wait_per_byte < 0) ? $urandom_range(0, 2) : wait_per_byte;
      end
      mc_ack = 1'b0;
      guard++;
    end
    if (guard >= 100) checkOutput("xfer_timeout", 32'(guard), 0);
    expect_val = longint'(loaded);
    if (!f3[2] && n < 4 && loaded[8 * n - 1]) expect_val = expect_val - (longint'(1) << (8 * n));
    checkOutput("done_stall", 32'(stall_req), 0);
    checkOutput("done_req", 32'(mc_req), 0);
    checkOutput("done_wd", 32'(mem_wd), 32'(wd));
    checkOutput("done_wreg", 32'(mem_wreg), store ? 0 : 32'(wreg));
    checkOutput("done_wdata", mem_wdata, store ? 32'd0 : 32'(expect_val));
    tick();
  endtask

  initial begin
    rst = 1'b1;
    mc_ack = 1'b0;
    mc_rdata = 8'd0;
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'hDEAD_BEEF;
    ex_mem_rd = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010;
    ex_mem_addr = 32'h40; ex_store_data = 32'd0;
    tick();
    checkOutput("rst_stall", 32'(stall_req), 0);
    checkOutput("rst_wreg", 32'(mem_wreg), 0);
    checkOutput("rst_wd", 32'(mem_wd), 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_req", 32'(mc_req), 0);
    checkOutput("rst_addr", mc_addr, 0);
    tick();
    rst = 1'b0;
    ex_mem_rd = 1'b0;

    applyStimulus(0, 0, 3'b000, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 0);

    mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
    applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 0);
    mem[32'h200] = 8'h80;
    applyStimulus(1, 0, 3'b000, 32'h200, 32'h0, 32'h0, 5'd8, 1'b1, 0);
    applyStimulus(1, 0, 3'b100, 32'h200, 32'h0, 32'h0, 5'd9, 1'b1, 0);
    mem[32'h300] = 8'hFE; mem[32'h301] = 8'hFF;
    applyStimulus(1, 0, 3'b001, 32'h300, 32'h0, 32'h0, 5'd10, 1'b1, 0);
    applyStimulus(0, 1, 3'b001, 32'h2000, 32'hAABBCCDD, 32'h0, 5'd11, 1'b1, 0);
    checkOutput("sh_byte0", 32'(mem[32'h2000]), 32'hDD);
    checkOutput("sh_byte1", 32'(mem[32'h2001]), 32'hCC);
    applyStimulus(0, 1, 3'b010, 32'h3000, 32'h11223344, 32'h0, 5'd12, 1'b0, 3);
    applyStimulus(1, 0, 3'b010, 32'h3000, 32'h0, 32'h0, 5'd13, 1'b1, 2);
    applyStimulus(1, 0, 3'b101, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd14, 1'b1, 0);

    // Reset in the middle of a word load, then a fresh load must not see old bytes.
    ex_mem_rd = 1'b1; ex_mem_we = 1'b0; ex_funct3 = 3'b010; ex_mem_addr = 32'h500;
    ex_wd = 5'd15; ex_wreg = 1'b1;
    tick();
    mc_ack = 1'b1; mc_rdata = 8'hAA; tick();
    mc_ack = 1'b1; mc_rdata = 8'hBB; tick();
    mc_ack = 1'b0; rst = 1'b1;
    ex_mem_rd = 1'b0;
    #1;
    checkOutput("midrst_stall", 32'(stall_req), 0);
    checkOutput("midrst_wreg", 32'(mem_wreg), 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("postrst_req", 32'(mc_req), 0);
    checkOutput("postrst_stall", 32'(stall_req), 0);
    mem[32'h600] = 8'h01; mem[32'h601] = 8'h02; mem[32'h602] = 8'h03; mem[32'h603] = 8'h04;
    applyStimulus(1, 0, 3'b010, 32'h600, 32'h0, 32'h0, 5'd16, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [31:0] ra;
      kind = $urandom_range(0, 3);
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 63));
      applyStimulus(kind[0], kind[1], 3'($urandom), ra, $urandom, $urandom,
                    5'($urandom), 1'($urandom), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
